typ_fifo: RTL and testbench

//   Type-parameterised synchronous FIFO. It sits directly downstream of the typed

---
 rtl/typ_fifo_if.sv | 31 +++
 rtl/typ_fifo.sv | 64 ++++++
 tb/tb_typ_fifo.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/typ_fifo_if.sv
// typ_fifo_if: valid/ready handshake bundle for the typed FIFO.
// master = the producer/consumer side (bench or upstream/downstream logic),
// slave  = the FIFO itself.
interface typ_fifo_if #(
  parameter type TYP = byte
);
  logic in_vld;
  logic in_rdy;
  TYP   in_dat;
  logic out_vld;
  logic out_rdy;
  TYP   out_dat;

  modport master (
    output in_vld,
    output in_dat,
    output out_rdy,
    input  in_rdy,
    input  out_vld,
    input  out_dat
  );

  modport slave (
    input  in_vld,
    input  in_dat,
    input  out_rdy,
    output in_rdy,
    output out_vld,
    output out_dat
  );
endinterface

// File: rtl/typ_fifo.sv
// typ_fifo: type-parameterised synchronous first-word-fall-through FIFO.
// Payload bits are copied verbatim, so packed multidimensional types keep
// their layout. Pointers wrap by explicit compare, so DEPTH need not be a
// power of two. The storage array is intentionally left unreset; out_dat is
// masked to zero whenever the FIFO is empty so it never shows stale or X data.
module typ_fifo #(
  parameter type TYP   = byte,
  parameter int  DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  typ_fifo_if.slave                  bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output int                         siz
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  TYP            mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;

  // Advance a pointer, returning to entry 0 after the last entry.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags come from registered occupancy only; in_rdy never looks at out_rdy,
  // so a full FIFO refuses a push even when a pop happens in the same cycle.
  always_comb begin
    bus.in_rdy  = (count != CW'(DEPTH));
    bus.out_vld = (count != '0);
    bus.out_dat = bus.out_vld ? mem[rd_ptr] : '0;
    push        = bus.in_vld & bus.in_rdy;
    pop         = bus.out_vld & bus.out_rdy;
    siz         = $bits(TYP);
  end

  // Pointer and occupancy bookkeeping; reset discards contents immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Payload storage write; no reset so the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_dat;
  end

endmodule

// File: tb/tb_typ_fifo.sv
// tb_typ_fifo: checks typ_fifo with byte/DEPTH=4, int/DEPTH=3 and
// bit[3:0][3:0]/DEPTH=4 payloads against a bench-side queue model.
module tb_typ_fifo;

  typedef bit [3:0][3:0] nib4_t;

  logic clk;
  logic rst_n;

  typ_fifo_if #(.TYP(byte))   bif ();
  typ_fifo_if #(.TYP(int))    iif ();
  typ_fifo_if #(.TYP(nib4_t)) nif ();

  logic [2:0] b_count;
  logic [1:0] i_count;
  logic [2:0] n_count;
  int         b_siz;
  int         i_siz;
  int         n_siz;

  typ_fifo #(.TYP(byte), .DEPTH(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bif), .count(b_count), .siz(b_siz));
  typ_fifo #(.TYP(int), .DEPTH(3)) dut_i (
    .clk(clk), .rst_n(rst_n), .bus(iif), .count(i_count), .siz(i_siz));
  typ_fifo #(.TYP(nib4_t), .DEPTH(4)) dut_n (
    .clk(clk), .rst_n(rst_n), .bus(nif), .count(n_count), .siz(n_siz));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // byte-FIFO reference model
  byte bq[$];
  int  bcount = 0;

  typedef struct {
    logic       vld;
    byte        dat;
    logic       rdy;
    logic [2:0] exp_count;
    logic       exp_in_rdy;
    logic       exp_out_vld;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle on the byte FIFO starting just after a falling edge,
  // score the current outputs against the model, then advance one clock.
  task automatic applyStimulus(input logic v, input byte d, input logic r);
    logic m_vld, m_rdy;
    bif.in_vld  = v;
    bif.in_dat  = d;
    bif.out_rdy = r;
    #1;
    m_vld = (bcount != 0);
    m_rdy = (bcount != 4);
    chk("b_out_vld", 32'(bif.out_vld), 32'(m_vld));
    chk("b_in_rdy",  32'(bif.in_rdy),  32'(m_rdy));
    if (!m_vld) chk("b_empty_dat", 32'(bif.out_dat), 32'h0);
    if (m_vld && r) begin
      if (bq.size() == 0) chk("b_sb_underrun", 32'h1, 32'h0);
      else chk("b_pop_dat", 32'(bif.out_dat), 32'(bq.pop_front()));
    end
    if (v && m_rdy) bq.push_back(d);
    bcount = bcount + int'(v && m_rdy) - int'(m_vld && r);
    @(posedge clk);
    @(negedge clk);
    bif.in_vld  = 1'b0;
    bif.out_rdy = 1'b0;
  endtask

  task automatic checkOutput(input vec_t e, input int idx);
    chk($sformatf("v%0d_count", idx),   32'(b_count),      32'(e.exp_count));
    chk($sformatf("v%0d_in_rdy", idx),  32'(bif.in_rdy),  32'(e.exp_in_rdy));
    chk($sformatf("v%0d_out_vld", idx), 32'(bif.out_vld), 32'(e.exp_out_vld));
  endtask

  function automatic vec_t mk(input logic v, input byte d, input logic r,
                              input logic [2:0] c, input logic ir, input logic ov);
    vec_t t;
    t.vld = v; t.dat = d; t.rdy = r;
    t.exp_count = c; t.exp_in_rdy = ir; t.exp_out_vld = ov;
    return t;
  endfunction

  initial begin
    int   iq[$];
    int   iexp;
    int   icnt;

    bif.in_vld = 0; bif.in_dat = 0; bif.out_rdy = 0;
    iif.in_vld = 0; iif.in_dat = 0; iif.out_rdy = 0;
    nif.in_vld = 0; nif.in_dat = '0; nif.out_rdy = 0;
    rst_n = 1'b0;

    // Reset values
    #2;
    chk("rst_count",   32'(b_count),      32'h0);
    chk("rst_out_vld", 32'(bif.out_vld), 32'h0);
    chk("rst_in_rdy",  32'(bif.in_rdy),  32'h1);
    chk("rst_out_dat", 32'(bif.out_dat), 32'h0);
    chk("siz_byte",    32'(b_siz),        32'd8);
    chk("siz_int",     32'(i_siz),        32'd32);
    chk("siz_nib4",    32'(n_siz),        32'd16);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Fill, overfill, drain, empty push&pop, full push&pop
    vecs.push_back(mk(1, 8'h11, 0, 3'd1, 1, 1));
    vecs.push_back(mk(1, 8'h22, 0, 3'd2, 1, 1));
    vecs.push_back(mk(1, 8'h33, 0, 3'd3, 1, 1));
    vecs.push_back(mk(1, 8'h44, 0, 3'd4, 0, 1));
    vecs.push_back(mk(1, 8'h55, 0, 3'd4, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd3, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd2, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd0, 1, 0));
    vecs.push_back(mk(0, 8'h00, 1, 3'd0, 1, 0));
    vecs.push_back(mk(1, 8'h66, 1, 3'd1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd0, 1, 0));
    vecs.push_back(mk(1, 8'h11, 0, 3'd1, 1, 1));
    vecs.push_back(mk(1, 8'h22, 0, 3'd2, 1, 1));
    vecs.push_back(mk(1, 8'h33, 0, 3'd3, 1, 1));
    vecs.push_back(mk(1, 8'h44, 0, 3'd4, 0, 1));
    vecs.push_back(mk(1, 8'h77, 1, 3'd3, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd2, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd1, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 3'd0, 1, 0));

    for (int k = 0; k < vecs.size(); k++) begin
      applyStimulus(vecs[k].vld, vecs[k].dat, vecs[k].rdy);
      checkOutput(vecs[k], k);
    end
    chk("b_sb_drained", 32'(bq.size()), 32'h0);

    // int FIFO, DEPTH=3: continuous streaming across pointer wrap
    icnt = 0;
    for (int k = 0; k < 11; k++) begin
      iif.in_vld  = (k < 10);
      iif.in_dat  = 32'hDEAD0000 + k;
      iif.out_rdy = 1'b1;
      #1;
      chk("i_out_vld", 32'(iif.out_vld), 32'(icnt != 0));
      if (icnt != 0) begin
        iexp = iq.pop_front();
        chk($sformatf("i_dat%0d", k), 32'(iif.out_dat), 32'(iexp));
      end
      if (k < 10) iq.push_back(32'hDEAD0000 + k);
      icnt = (k < 10) ? 1 : 0;
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("i_count%0d", k), 32'(i_count), 32'(icnt));
    end
    iif.in_vld  = 1'b0;
    iif.out_rdy = 1'b0;

    // Packed 2-D payload keeps its nibble layout
    nif.in_vld = 1'b1;
    nif.in_dat = 16'hA5C3;
    @(posedge clk);
    @(negedge clk);
    nif.in_vld = 1'b0;
    chk("n_out_vld", 32'(nif.out_vld),    32'h1);
    chk("n_nib3",    32'(nif.out_dat[3]), 32'hA);
    chk("n_nib0",    32'(nif.out_dat[0]), 32'h3);
    chk("n_word",    32'(nif.out_dat),    32'hA5C3);
    nif.out_rdy = 1'b1;
    @(posedge clk);
    @(negedge clk);
    nif.out_rdy = 1'b0;
    chk("n_count_after_pop", 32'(n_count), 32'h0);

    // Mid-operation reset between edges discards contents at once
    applyStimulus(1, 8'hAA, 0);
    applyStimulus(1, 8'hBB, 0);
    chk("pre_rst_count", 32'(b_count), 32'd2);
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_vld", 32'(bif.out_vld), 32'h0);
    chk("async_rst_count",   32'(b_count),      32'h0);
    bq.delete();
    bcount = 0;
    #1;
    rst_n = 1'b1;
    applyStimulus(1, 8'hCC, 0);
    chk("post_rst_count", 32'(b_count), 32'h1);
    applyStimulus(0, 8'h00, 1);
    chk("post_rst_empty", 32'(b_count), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
